// File: rtl/floating_scalar_alu_pkg.sv
// Shared types and constants for the floating scalar ALU: op encoding, operand
// classes, FSM states and the canonical special values.
package floating_scalar_alu_pkg;

   typedef logic [31:0] data_t;

   typedef enum logic [2:0] {
      FADD = 3'd0,
      FSUB = 3'd1,
      FMUL = 3'd2,
      FMIN = 3'd3,
      FMAX = 3'd4,
      FEQ  = 3'd5,
      FLT  = 3'd6,
      FLE  = 3'd7
   } fp_op_t;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORMAL,
      FP_INF,
      FP_NAN
   } fp_class_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UNPACK,
      ST_EXEC,
      ST_NORM,
      ST_DONE
   } alu_state_t;

   localparam data_t FP_CANON_NAN = 32'h7FC00000;
   localparam data_t FP_POS_INF   = 32'h7F800000;
   localparam data_t FP_NEG_INF   = 32'hFF800000;

   // Denormals fold into FP_ZERO; the ALU never sees them as numbers.
   function automatic fp_class_t fp_classify(input data_t x);
      if (x[30:23] == 8'd0)
         return FP_ZERO;
      if (x[30:23] == 8'hFF)
         return (x[22:0] == 23'd0) ? FP_INF : FP_NAN;
      return FP_NORMAL;
   endfunction

endpackage

// File: rtl/fp_leading_zero_count.sv
// Leading-zero count of a 48-bit mantissa; an all-zero input reports 48.
module fp_leading_zero_count (
   input  logic [47:0] value,
   output logic [5:0]  count
);

   always_comb begin
      count = 6'd48;
      for (int i = 0; i < 48; i++) begin
         if (value[i])
            count = 6'(47 - i);
      end
   end

endmodule

// File: rtl/floating_scalar_alu.sv
// Multi-cycle single-precision scalar ALU: IDLE -> UNPACK -> EXEC -> NORM -> DONE,
// round-toward-zero, denormals flushed to signed zero.
module floating_scalar_alu
   import floating_scalar_alu_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  start,
   input  logic [2:0]            op,
   input  logic [DATA_WIDTH-1:0] rs1,
   input  logic [DATA_WIDTH-1:0] rs2,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] alu_out
);

   if (DATA_WIDTH != 32 || LATENCY != 4) begin : g_bad_param
      $error("floating_scalar_alu supports only DATA_WIDTH=32 with LATENCY=4");
   end

   alu_state_t state;
   logic       done_q;

   fp_op_t op_p0;
   data_t  rs1_p0, rs2_p0;

   logic        sa_p1, sb_p1;
   logic [7:0]  ea_p1, eb_p1;
   logic [23:0] ma_p1, mb_p1;
   fp_class_t   ca_p1, cb_p1;

   logic               spec_p2;
   data_t              spec_val_p2;
   logic               sign_p2;
   logic signed [10:0] exp_p2;
   logic [47:0]        mant_p2;

   function automatic logic num_less(input logic sx, input logic [31:0] mx, input logic zx,
                                     input logic sy, input logic [31:0] my, input logic zy);
      if (zx && zy)
         return 1'b0;
      if (sx != sy)
         return sx;
      return sx ? (mx > my) : (mx < my);
   endfunction

   // Truncated result with saturation to infinity and flush to signed zero.
   function automatic data_t fp_pack(input logic s, input logic signed [10:0] e, input logic [22:0] f);
      if (e >= 11'sd255)
         return s ? FP_NEG_INF : FP_POS_INF;
      if (e <= 11'sd0)
         return {s, 31'd0};
      return {s, e[7:0], f};
   endfunction

   // ---- UNPACK stage boundary ----
   fp_class_t ca_n, cb_n;
   assign ca_n = fp_classify(rs1_p0);
   assign cb_n = fp_classify(rs2_p0);

   // ---- EXEC stage boundary ----
   logic               spec_x, sign_x, sb_eff, a_nan, b_nan, a_inf, b_inf, za, zb;
   logic               a_bigger, lt_ab, lt_ba, eq_ab, ord_lt_ab, ord_lt_ba;
   data_t              spec_val_x;
   logic signed [10:0] exp_x;
   logic [47:0]        mant_x, prod;
   logic [31:0]        mag_a, mag_b;
   logic [7:0]         e_big, e_small, shift_d;
   logic [23:0]        m_big, m_small, m_small_sh;
   logic [24:0]        sum25;

   always_comb begin
      sb_eff     = sb_p1 ^ (op_p0 == FSUB);
      a_nan      = (ca_p1 == FP_NAN);
      b_nan      = (cb_p1 == FP_NAN);
      a_inf      = (ca_p1 == FP_INF);
      b_inf      = (cb_p1 == FP_INF);
      za         = (ca_p1 == FP_ZERO);
      zb         = (cb_p1 == FP_ZERO);
      mag_a      = {ea_p1, ma_p1};
      mag_b      = {eb_p1, mb_p1};
      lt_ab      = num_less(sa_p1, mag_a, za, sb_p1, mag_b, zb);
      lt_ba      = num_less(sb_p1, mag_b, zb, sa_p1, mag_a, za);
      eq_ab      = (za && zb) || (sa_p1 == sb_p1 && mag_a == mag_b);
      ord_lt_ab  = lt_ab || (za && zb && sa_p1 && !sb_p1);
      ord_lt_ba  = lt_ba || (za && zb && sb_p1 && !sa_p1);

      a_bigger   = (mag_a >= mag_b);
      e_big      = a_bigger ? ea_p1 : eb_p1;
      e_small    = a_bigger ? eb_p1 : ea_p1;
      m_big      = a_bigger ? ma_p1 : mb_p1;
      m_small    = a_bigger ? mb_p1 : ma_p1;
      shift_d    = e_big - e_small;
      m_small_sh = (shift_d > 8'd23) ? 24'd0 : (m_small >> shift_d);
      sum25      = (sa_p1 == sb_eff) ? ({1'b0, m_big} + {1'b0, m_small_sh})
                                     : ({1'b0, m_big} - {1'b0, m_small_sh});
      prod       = {24'd0, ma_p1} * {24'd0, mb_p1};

      spec_x     = 1'b1;
      spec_val_x = 32'd0;
      sign_x     = 1'b0;
      exp_x      = 11'sd0;
      mant_x     = 48'd0;
      case (op_p0)
         FADD, FSUB: begin
            if (a_nan || b_nan)
               spec_val_x = FP_CANON_NAN;
            else if (a_inf && b_inf)
               spec_val_x = (sa_p1 != sb_eff) ? FP_CANON_NAN : (sa_p1 ? FP_NEG_INF : FP_POS_INF);
            else if (a_inf)
               spec_val_x = sa_p1 ? FP_NEG_INF : FP_POS_INF;
            else if (b_inf)
               spec_val_x = sb_eff ? FP_NEG_INF : FP_POS_INF;
            else if (za && zb)
               spec_val_x = {sa_p1 & sb_eff, 31'd0};
            else if (za)
               spec_val_x = {sb_eff, rs2_p0[30:0]};
            else if (zb)
               spec_val_x = rs1_p0;
            else if (sum25 == 25'd0)
               spec_val_x = 32'd0;
            else begin
               spec_x = 1'b0;
               sign_x = a_bigger ? sa_p1 : sb_eff;
               exp_x  = $signed({3'd0, e_big});
               mant_x = {sum25, 23'd0};
            end
         end
         FMUL: begin
            if (a_nan || b_nan || (a_inf && zb) || (za && b_inf))
               spec_val_x = FP_CANON_NAN;
            else if (a_inf || b_inf)
               spec_val_x = (sa_p1 ^ sb_p1) ? FP_NEG_INF : FP_POS_INF;
            else if (za || zb)
               spec_val_x = {sa_p1 ^ sb_p1, 31'd0};
            else begin
               spec_x = 1'b0;
               sign_x = sa_p1 ^ sb_p1;
               exp_x  = $signed({3'd0, ea_p1}) + $signed({3'd0, eb_p1}) - 11'sd127;
               mant_x = prod;
            end
         end
         FMIN, FMAX: begin
            if (a_nan && b_nan)
               spec_val_x = FP_CANON_NAN;
            else if (a_nan)
               spec_val_x = rs2_p0;
            else if (b_nan)
               spec_val_x = rs1_p0;
            else if (op_p0 == FMIN)
               spec_val_x = ord_lt_ba ? rs2_p0 : rs1_p0;
            else
               spec_val_x = ord_lt_ab ? rs2_p0 : rs1_p0;
         end
         FEQ:     spec_val_x = {31'd0, !(a_nan || b_nan) && eq_ab};
         FLT:     spec_val_x = {31'd0, !(a_nan || b_nan) && lt_ab};
         FLE:     spec_val_x = {31'd0, !(a_nan || b_nan) && (lt_ab || eq_ab)};
         default: spec_val_x = FP_CANON_NAN;
      endcase
   end

   // ---- NORM stage boundary ----
   logic [5:0]         lz;
   logic [47:0]        norm_m;
   logic signed [10:0] exp_norm;
   data_t              result_n;
   logic               unused_bits;

   fp_leading_zero_count u_lzc (
      .value (mant_p2),
      .count (lz)
   );

   assign norm_m      = mant_p2 << lz;
   assign exp_norm    = exp_p2 + 11'sd1 - $signed({5'd0, lz});
   assign result_n    = spec_p2 ? spec_val_p2 : fp_pack(sign_p2, exp_norm, norm_m[46:24]);
   assign unused_bits = ^{norm_m[47], norm_m[23:0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         busy    <= 1'b0;
         done_q  <= 1'b0;
         alu_out <= '0;
         op_p0   <= FADD;
         rs1_p0  <= '0;
         rs2_p0  <= '0;
      end else if (enable) begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_p0  <= fp_op_t'(op);
                  rs1_p0 <= rs1;
                  rs2_p0 <= rs2;
                  busy   <= 1'b1;
                  state  <= ST_UNPACK;
               end
            end
            ST_UNPACK: state <= ST_EXEC;
            ST_EXEC:   state <= ST_NORM;
            ST_NORM: begin
               alu_out <= result_n;
               done_q  <= 1'b1;
               state   <= ST_DONE;
            end
            ST_DONE: begin
               done_q <= 1'b0;
               busy   <= 1'b0;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (enable && state == ST_UNPACK) begin
         sa_p1 <= rs1_p0[31];
         sb_p1 <= rs2_p0[31];
         ca_p1 <= ca_n;
         cb_p1 <= cb_n;
         ea_p1 <= (ca_n == FP_ZERO) ? 8'd0 : rs1_p0[30:23];
         eb_p1 <= (cb_n == FP_ZERO) ? 8'd0 : rs2_p0[30:23];
         ma_p1 <= (ca_n == FP_ZERO) ? 24'd0 : {1'b1, (ca_n == FP_INF) ? 23'd0 : rs1_p0[22:0]};
         mb_p1 <= (cb_n == FP_ZERO) ? 24'd0 : {1'b1, (cb_n == FP_INF) ? 23'd0 : rs2_p0[22:0]};
      end
      if (enable && state == ST_EXEC) begin
         spec_p2     <= spec_x;
         spec_val_p2 <= spec_val_x;
         sign_p2     <= sign_x;
         exp_p2      <= exp_x;
         mant_p2     <= mant_x;
      end
   end

   // A frozen warp must not see its completion until it is re-enabled.
   assign done = done_q & enable;

endmodule

// File: tb/tb_floating_scalar_alu.sv
// Directed bench for floating_scalar_alu: arithmetic results, latency, start/enable
// handshake and mid-operation reset.
module tb_floating_scalar_alu;

   localparam logic [2:0] OP_FADD = 3'd0;
   localparam logic [2:0] OP_FSUB = 3'd1;
   localparam logic [2:0] OP_FMUL = 3'd2;
   localparam logic [2:0] OP_FMIN = 3'd3;
   localparam logic [2:0] OP_FMAX = 3'd4;
   localparam logic [2:0] OP_FEQ  = 3'd5;
   localparam logic [2:0] OP_FLT  = 3'd6;
   localparam logic [2:0] OP_FLE  = 3'd7;

   logic        clk = 1'b0;
   logic        reset, enable, start;
   logic [2:0]  op;
   logic [31:0] rs1, rs2;
   logic        busy, done;
   logic [31:0] alu_out;

   int passed = 0;
   int total  = 0;
   int cyc;
   int pulses;

   floating_scalar_alu #(.DATA_WIDTH(32), .LATENCY(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .enable  (enable),
      .start   (start),
      .op      (op),
      .rs1     (rs1),
      .rs2     (rs2),
      .busy    (busy),
      .done    (done),
      .alu_out (alu_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
   endtask

   // Called at a negedge; returns at the negedge of cycle 1 of the operation.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      op    = o;
      rs1   = a;
      rs2   = b;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int first, output int c);
      c = first;
      while (done !== 1'b1 && c < 20) begin
         @(negedge clk);
         c++;
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expected);
      int c;
      issue(o, a, b);
      wait_done(1, c);
      check({tag, "_latency"}, 32'(c), 32'd4);
      check(tag, alu_out, expected);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      reset  = 1'b1;
      enable = 1'b1;
      start  = 1'b0;
      op     = 3'd0;
      rs1    = 32'd0;
      rs2    = 32'd0;
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_alu_out", alu_out, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // 1.5 + 2.25 with busy window checked cycle by cycle
      issue(OP_FADD, 32'h3FC00000, 32'h40100000);
      check("fadd_busy_c1", {31'd0, busy}, 32'd1);
      check("fadd_done_c1", {31'd0, done}, 32'd0);
      wait_done(1, cyc);
      check("fadd_latency", 32'(cyc), 32'd4);
      check("fadd_busy_c4", {31'd0, busy}, 32'd1);
      check("fadd_result", alu_out, 32'h40700000);
      @(negedge clk);
      check("fadd_busy_c5", {31'd0, busy}, 32'd0);
      check("fadd_done_c5", {31'd0, done}, 32'd0);
      check("fadd_hold", alu_out, 32'h40700000);

      run_op("fmul_3x_m2", OP_FMUL, 32'h40400000, 32'hC0000000, 32'hC0C00000);
      run_op("fmul_ovf", OP_FMUL, 32'h7F7FFFFF, 32'h40000000, 32'h7F800000);
      run_op("fsub_cancel", OP_FSUB, 32'h3F800000, 32'h3F800000, 32'h00000000);
      run_op("fadd_inf_minf", OP_FADD, 32'h7F800000, 32'hFF800000, 32'h7FC00000);
      run_op("fmax_zeros", OP_FMAX, 32'h80000000, 32'h00000000, 32'h00000000);
      run_op("fmin_zeros", OP_FMIN, 32'h00000000, 32'h80000000, 32'h80000000);
      run_op("fmin_nan", OP_FMIN, 32'h7FC00000, 32'h3F800000, 32'h3F800000);
      run_op("flt_nan", OP_FLT, 32'h7FC00000, 32'h3F800000, 32'h00000000);
      run_op("fle_eq", OP_FLE, 32'h3F800000, 32'h3F800000, 32'h00000001);
      run_op("feq_pm_zero", OP_FEQ, 32'h80000000, 32'h00000000, 32'h00000001);
      run_op("flt_neg", OP_FLT, 32'hC0000000, 32'h3F800000, 32'h00000001);
      run_op("fmul_0_inf", OP_FMUL, 32'h00000000, 32'h7F800000, 32'h7FC00000);
      run_op("fmul_uflow", OP_FMUL, 32'h00800000, 32'h00800000, 32'h00000000);
      run_op("fsub_mixed", OP_FSUB, 32'h3F800000, 32'h40000000, 32'hBF800000);

      // start held during cycles 1-3 must be ignored
      issue(OP_FADD, 32'h3FC00000, 32'h40100000);
      op    = OP_FMUL;
      rs1   = 32'h40400000;
      rs2   = 32'hC0000000;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      check("hs_done_c4", {31'd0, done}, 32'd1);
      check("hs_result", alu_out, 32'h40700000);
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      check("hs_extra_done", 32'(pulses), 32'd0);
      check("hs_busy_idle", {31'd0, busy}, 32'd0);

      // enable low for cycles 2-4 stretches done to cycle 7
      issue(OP_FMUL, 32'h40400000, 32'hC0000000);
      @(negedge clk);
      enable = 1'b0;
      repeat (2) @(negedge clk);
      check("en_busy_frozen", {31'd0, busy}, 32'd1);
      check("en_done_frozen", {31'd0, done}, 32'd0);
      @(negedge clk);
      enable = 1'b1;
      wait_done(5, cyc);
      check("en_latency", 32'(cyc), 32'd7);
      check("en_result", alu_out, 32'hC0C00000);
      @(negedge clk);

      // reset at cycle 2 aborts the operation
      issue(OP_FMUL, 32'h40400000, 32'h40400000);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("rst_mid_busy", {31'd0, busy}, 32'd0);
      check("rst_mid_alu_out", alu_out, 32'd0);
      check("rst_mid_done", {31'd0, done}, 32'd0);
      reset  = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      check("rst_mid_no_done", 32'(pulses), 32'd0);
      run_op("post_rst_fadd", OP_FADD, 32'h3FC00000, 32'h40100000, 32'h40700000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
